window_3x3_gen: RTL

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator for 8-bit raster-order pixels.
// Two line buffers hold the previous rows; a two-column shift register plus the incoming
// column form each window, which is registered onto w1..w9.
// Build option WINDOW_BORDER_REPLICATE_EN: when defined, out-of-frame taps replicate the
// nearest in-frame pixel; when undefined, out-of-frame taps read as zero. Timing is the same.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  output logic       in_ready,
  output logic [7:0] w1,
  output logic [7:0] w2,
  output logic [7:0] w3,
  output logic [7:0] w4,
  output logic [7:0] w5,
  output logic [7:0] w6,
  output logic [7:0] w7,
  output logic [7:0] w8,
  output logic [7:0] w9,
  output logic       out_valid,
  output logic       frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {FILL, RUN, EOL, FLUSH} state_t;

  state_t        state, next_state;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] rd_idx;
  logic          accept, emit, shift_en, ready_next;
  logic          top_oob, bot_oob, left_oob, right_oob;
  logic [7:0]    lb_top [IMG_WIDTH];
  logic [7:0]    lb_mid [IMG_WIDTH];
  logic [23:0]   col_l_p0, col_c_p0, new_col;
  logic [71:0]   win;

  // Apply the border rule to the top/bottom taps of one column {top, mid, bot}.
  function automatic logic [23:0] fix_rows(input logic [23:0] col, input logic t_oob,
                                           input logic b_oob);
    logic [7:0] top, mid, bot;
    {top, mid, bot} = col;
`ifdef WINDOW_BORDER_REPLICATE_EN
    if (t_oob) top = mid;
    if (b_oob) bot = mid;
`else
    if (t_oob) top = 8'd0;
    if (b_oob) bot = 8'd0;
`endif
    return {top, mid, bot};
  endfunction

  // Assemble {w1..w9} from three columns, applying the border rule on rows then columns.
  function automatic logic [71:0] make_window(input logic [23:0] lcol, input logic [23:0] ccol,
                                              input logic [23:0] rcol, input logic t_oob,
                                              input logic b_oob, input logic l_oob,
                                              input logic r_oob);
    logic [23:0] l, c, r;
    l = fix_rows(lcol, t_oob, b_oob);
    c = fix_rows(ccol, t_oob, b_oob);
    r = fix_rows(rcol, t_oob, b_oob);
`ifdef WINDOW_BORDER_REPLICATE_EN
    if (l_oob) l = c;
    if (r_oob) r = c;
`else
    if (l_oob) l = 24'd0;
    if (r_oob) r = 24'd0;
`endif
    return {l[23:16], c[23:16], r[23:16], l[15:8], c[15:8], r[15:8], l[7:0], c[7:0], r[7:0]};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= next_state;
  end

  // Next-state: row 0 fills, later rows run, each row end costs one bubble, last row flushes.
  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (accept && col_q == COL_LAST) next_state = RUN;
      RUN:     if (accept && col_q == COL_LAST) next_state = EOL;
      EOL:     next_state = (row_q == ROW_LAST) ? FLUSH : RUN;
      FLUSH:   if (col_q == COL_LAST) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // Output decode: emit strobe, border flags, line-buffer read index and shift enable.
  always_comb begin
    accept    = in_valid && in_ready;
    rd_idx    = col_q;
    emit      = 1'b0;
    shift_en  = accept;
    top_oob   = 1'b0;
    bot_oob   = 1'b0;
    left_oob  = 1'b0;
    right_oob = 1'b0;
    if (state == FLUSH && col_q != COL_LAST) rd_idx = col_q + CW'(1);
    case (state)
      RUN: begin
        emit     = accept && (col_q != '0);
        top_oob  = (row_q == RW'(1));
        left_oob = (col_q == CW'(1));
      end
      EOL: begin
        emit      = 1'b1;
        top_oob   = (row_q == RW'(1));
        right_oob = 1'b1;
        shift_en  = (row_q == ROW_LAST);
      end
      FLUSH: begin
        emit      = 1'b1;
        shift_en  = 1'b1;
        bot_oob   = 1'b1;
        left_oob  = (col_q == '0);
        right_oob = (col_q == COL_LAST);
      end
      default: ;
    endcase
    ready_next = (next_state == FILL || next_state == RUN) && (state != FLUSH);
    new_col    = {lb_top[rd_idx], lb_mid[rd_idx], in_pixel};
    win        = make_window(col_l_p0, col_c_p0, new_col, top_oob, bot_oob, left_oob, right_oob);
  end

  // Row/column counters: input position in FILL/RUN, emitted column in FLUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      case (state)
        FILL, RUN: if (accept) begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            if (state == FILL) row_q <= RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        EOL: if (row_q != ROW_LAST) row_q <= row_q + RW'(1);
        FLUSH: begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= '0;
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0: line buffers age by one row per accepted pixel; columns shift left.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col_q] <= lb_mid[col_q];
      lb_mid[col_q] <= in_pixel;
    end
    if (shift_en) begin
      col_l_p0 <= col_c_p0;
      col_c_p0 <= new_col;
    end
  end

  // Stage p1: registered window, valid and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {w1, w2, w3, w4, w5, w6, w7, w8, w9} <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      if (emit) {w1, w2, w3, w4, w5, w6, w7, w8, w9} <= win;
      out_valid  <= emit;
      frame_done <= (state == FLUSH) && (col_q == COL_LAST);
      in_ready   <= ready_next;
    end
  end
endmodule
